// File: rtl/sgpr_busy_pkg.sv
// Shared encodings for the SGPR busy scoreboard: size codes, default geometry and
// the size-code to word-count mapping.
package sgpr_busy_pkg;

    localparam int NUM_SGPR_DEF = 104;
    localparam int ADDR_W_DEF   = 7;
    localparam int CNT_W_DEF    = 8;

    typedef enum logic [1:0] {
        SZ_1 = 2'd0,
        SZ_2 = 2'd1,
        SZ_4 = 2'd2,
        SZ_8 = 2'd3
    } size_e;

    function automatic int size_words(input logic [1:0] code);
        case (code)
            SZ_1:    return 1;
            SZ_2:    return 2;
            SZ_4:    return 4;
            default: return 8;
        endcase
    endfunction

endpackage

// File: rtl/sgpr_range_mask.sv
// Combinational decoder: base address + size code -> NUM_SGPR-bit mask of the range,
// wrapping modulo NUM_SGPR (addresses at or above NUM_SGPR are reduced first).
import sgpr_busy_pkg::*;

module sgpr_range_mask #(
    parameter int NUM_SGPR = NUM_SGPR_DEF,
    parameter int ADDR_W   = ADDR_W_DEF
) (
    input  logic [ADDR_W-1:0]   addr,
    input  logic [1:0]          size,
    output logic [NUM_SGPR-1:0] mask
);

    int base_i;
    int n_i;

    assign base_i = int'(addr) % NUM_SGPR;
    assign n_i    = size_words(size);

    // Bit b belongs to the range when its distance from base, walking upward with wrap, is < n.
    for (genvar b = 0; b < NUM_SGPR; b++) begin : g_bit
        assign mask[b] = (((b - base_i + NUM_SGPR) % NUM_SGPR) < n_i);
    end

endmodule

// File: rtl/sgpr_busy_table_ctrl.sv
// SGPR busy-table controller for one wavefront: set on issue, clear on SALU/LSU writeback,
// registered operand-free checks. Optional sticky protocol checker under SGPR_BUSY_ERR_CHK_EN.
import sgpr_busy_pkg::*;

module sgpr_busy_table_ctrl #(
    parameter int NUM_SGPR = NUM_SGPR_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int CNT_W    = CNT_W_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                set_valid,
    input  logic [ADDR_W-1:0]   set_addr,
    input  logic [1:0]          set_size,
    input  logic                salu_clr_valid,
    input  logic [ADDR_W-1:0]   salu_clr_addr,
    input  logic [1:0]          salu_clr_size,
    input  logic                lsu_clr_valid,
    input  logic [ADDR_W-1:0]   lsu_clr_addr,
    input  logic [1:0]          lsu_clr_size,
    input  logic                flush,
    input  logic                chk_valid,
    input  logic [ADDR_W-1:0]   chk_addr0,
    input  logic [ADDR_W-1:0]   chk_addr1,
    input  logic [ADDR_W-1:0]   chk_addr2,
    input  logic [1:0]          chk_size0,
    input  logic [1:0]          chk_size1,
    input  logic [1:0]          chk_size2,
    input  logic                chk_en0,
    input  logic                chk_en1,
    input  logic                chk_en2,
    output logic                chk_done,
    output logic                chk_free,
    output logic [NUM_SGPR-1:0] busy_q,
    output logic [CNT_W-1:0]    busy_cnt,
    output logic                err
);

    // Every *_valid is a single-cycle strobe with no ready: the table accepts every request in
    // the cycle it is presented, and chk_done pulses exactly one cycle after each chk_valid.

    logic [NUM_SGPR-1:0] set_raw, salu_raw, lsu_raw;
    logic [NUM_SGPR-1:0] chk_raw0, chk_raw1, chk_raw2;
    logic [NUM_SGPR-1:0] set_m, salu_m, lsu_m;
    logic [NUM_SGPR-1:0] busy_d;
    logic                chk_free_d;

    sgpr_range_mask #(.NUM_SGPR(NUM_SGPR), .ADDR_W(ADDR_W)) u_set_mask (
        .addr(set_addr), .size(set_size), .mask(set_raw));
    sgpr_range_mask #(.NUM_SGPR(NUM_SGPR), .ADDR_W(ADDR_W)) u_salu_mask (
        .addr(salu_clr_addr), .size(salu_clr_size), .mask(salu_raw));
    sgpr_range_mask #(.NUM_SGPR(NUM_SGPR), .ADDR_W(ADDR_W)) u_lsu_mask (
        .addr(lsu_clr_addr), .size(lsu_clr_size), .mask(lsu_raw));
    sgpr_range_mask #(.NUM_SGPR(NUM_SGPR), .ADDR_W(ADDR_W)) u_chk_mask0 (
        .addr(chk_addr0), .size(chk_size0), .mask(chk_raw0));
    sgpr_range_mask #(.NUM_SGPR(NUM_SGPR), .ADDR_W(ADDR_W)) u_chk_mask1 (
        .addr(chk_addr1), .size(chk_size1), .mask(chk_raw1));
    sgpr_range_mask #(.NUM_SGPR(NUM_SGPR), .ADDR_W(ADDR_W)) u_chk_mask2 (
        .addr(chk_addr2), .size(chk_size2), .mask(chk_raw2));

    assign set_m  = {NUM_SGPR{set_valid}} & set_raw;
    assign salu_m = {NUM_SGPR{salu_clr_valid}} & salu_raw;
    assign lsu_m  = {NUM_SGPR{lsu_clr_valid}} & lsu_raw;

    // Set is OR-ed in after the clears so a fresh allocation survives a stale writeback.
    assign busy_d = flush ? '0 : ((busy_q & ~salu_m & ~lsu_m) | set_m);

    // Check looks only at the registered bitmap: same-cycle sets, clears and flush are invisible.
    assign chk_free_d = ~((chk_en0 & |(chk_raw0 & busy_q)) |
                          (chk_en1 & |(chk_raw1 & busy_q)) |
                          (chk_en2 & |(chk_raw2 & busy_q)));

    function automatic logic [CNT_W-1:0] popcount(input logic [NUM_SGPR-1:0] v);
        logic [CNT_W-1:0] c;
        c = '0;
        for (int i = 0; i < NUM_SGPR; i++) begin
            c = c + CNT_W'(v[i]);
        end
        return c;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q   <= '0;
            busy_cnt <= '0;
            chk_done <= 1'b0;
            chk_free <= 1'b0;
        end else begin
            busy_q   <= busy_d;
            busy_cnt <= popcount(busy_d);
            chk_done <= chk_valid;
            chk_free <= chk_valid & chk_free_d;
        end
    end

`ifdef SGPR_BUSY_ERR_CHK_EN
    logic err_q;
    logic err_event;

    assign err_event = (|(set_m & busy_q)) |
                       (~flush & |((salu_m | lsu_m) & ~busy_q)) |
                       (set_valid & (set_size == SZ_8)) |
                       (salu_clr_valid & (salu_clr_size == SZ_8)) |
                       (lsu_clr_valid & (lsu_clr_size == SZ_8));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (err_event) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_sgpr_busy_table_ctrl.sv
// Directed bench for sgpr_busy_table_ctrl; expected err depends on SGPR_BUSY_ERR_CHK_EN.
module tb_sgpr_busy_table_ctrl;

    localparam int NUM_SGPR = 104;
    localparam int ADDR_W   = 7;
    localparam int CNT_W    = 8;

    logic                clk;
    logic                rst_n;
    logic                set_valid;
    logic [ADDR_W-1:0]   set_addr;
    logic [1:0]          set_size;
    logic                salu_clr_valid;
    logic [ADDR_W-1:0]   salu_clr_addr;
    logic [1:0]          salu_clr_size;
    logic                lsu_clr_valid;
    logic [ADDR_W-1:0]   lsu_clr_addr;
    logic [1:0]          lsu_clr_size;
    logic                flush;
    logic                chk_valid;
    logic [ADDR_W-1:0]   chk_addr0, chk_addr1, chk_addr2;
    logic [1:0]          chk_size0, chk_size1, chk_size2;
    logic                chk_en0, chk_en1, chk_en2;
    logic                chk_done;
    logic                chk_free;
    logic [NUM_SGPR-1:0] busy_q;
    logic [CNT_W-1:0]    busy_cnt;
    logic                err;

    int checks;
    int errors;
    logic [0:0] exp_q[$];
    logic       exp_err_dbl;

    sgpr_busy_table_ctrl #(.NUM_SGPR(NUM_SGPR), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .set_valid(set_valid), .set_addr(set_addr), .set_size(set_size),
        .salu_clr_valid(salu_clr_valid), .salu_clr_addr(salu_clr_addr), .salu_clr_size(salu_clr_size),
        .lsu_clr_valid(lsu_clr_valid), .lsu_clr_addr(lsu_clr_addr), .lsu_clr_size(lsu_clr_size),
        .flush(flush), .chk_valid(chk_valid),
        .chk_addr0(chk_addr0), .chk_addr1(chk_addr1), .chk_addr2(chk_addr2),
        .chk_size0(chk_size0), .chk_size1(chk_size1), .chk_size2(chk_size2),
        .chk_en0(chk_en0), .chk_en1(chk_en1), .chk_en2(chk_en2),
        .chk_done(chk_done), .chk_free(chk_free),
        .busy_q(busy_q), .busy_cnt(busy_cnt), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle_inputs();
        set_valid = 0; set_addr = '0; set_size = '0;
        salu_clr_valid = 0; salu_clr_addr = '0; salu_clr_size = '0;
        lsu_clr_valid = 0; lsu_clr_addr = '0; lsu_clr_size = '0;
        flush = 0; chk_valid = 0;
        chk_addr0 = '0; chk_addr1 = '0; chk_addr2 = '0;
        chk_size0 = '0; chk_size1 = '0; chk_size2 = '0;
        chk_en0 = 0; chk_en1 = 0; chk_en2 = 0;
    endtask

    // Apply the current inputs across one rising edge, then return them to idle.
    task automatic tick();
        @(posedge clk);
        #1;
        idle_inputs();
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_set(input int a, input int s);
        set_valid = 1; set_addr = ADDR_W'(a); set_size = 2'(s);
    endtask

    task automatic drive_chk0(input int a, input int s, input logic exp_free);
        chk_valid = 1; chk_addr0 = ADDR_W'(a); chk_size0 = 2'(s); chk_en0 = 1;
        exp_q.push_back(exp_free);
    endtask

    task automatic check_result(input string tag);
        logic [0:0] e;
        e = exp_q.pop_front();
        check({tag, "_done"}, 128'(chk_done), 128'(1'b1));
        check({tag, "_free"}, 128'(chk_free), 128'(e));
    endtask

    initial begin
        checks = 0;
        errors = 0;
`ifdef SGPR_BUSY_ERR_CHK_EN
        exp_err_dbl = 1'b1;
`else
        exp_err_dbl = 1'b0;
`endif
        idle_inputs();
        rst_n = 0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 128'(busy_q), 128'(0));
        check("rst_cnt", 128'(busy_cnt), 128'(0));
        check("rst_done", 128'(chk_done), 128'(0));
        check("rst_free", 128'(chk_free), 128'(0));
        check("rst_err", 128'(err), 128'(0));
        rst_n = 1;
        tick();

        // Set 10 size 4 words
        drive_set(10, 2);
        tick();
        check("set10_busy", 128'(busy_q), 128'(104'h3C00));
        check("set10_cnt", 128'(busy_cnt), 128'(4));

        // Check reg 12 busy, then free after SALU clear
        drive_chk0(12, 0, 1'b0);
        tick();
        check_result("chk12_busy");
        tick();
        check("chk_idle_done", 128'(chk_done), 128'(0));
        salu_clr_valid = 1; salu_clr_addr = 7'd10; salu_clr_size = 2'd2;
        tick();
        check("clr10_busy", 128'(busy_q), 128'(0));
        check("clr10_cnt", 128'(busy_cnt), 128'(0));
        drive_chk0(12, 0, 1'b1);
        tick();
        check_result("chk12_free");

        // Wrap at top of table
        drive_set(NUM_SGPR - 2, 2);
        tick();
        check("wrap_busy", 128'(busy_q), 128'({2'b11, 100'b0, 2'b11}));
        check("wrap_cnt", 128'(busy_cnt), 128'(4));
        flush = 1;
        tick();
        check("flush_busy", 128'(busy_q), 128'(0));

        // Out-of-range base reduced: 110 mod 104 = 6
        drive_set(110, 1);
        tick();
        check("oor_busy", 128'(busy_q), 128'(104'hC0));
        check("oor_cnt", 128'(busy_cnt), 128'(2));
        flush = 1;
        tick();

        // Set beats same-cycle clears
        drive_set(20, 1);
        lsu_clr_valid = 1; lsu_clr_addr = 7'd20; lsu_clr_size = 2'd0;
        salu_clr_valid = 1; salu_clr_addr = 7'd21; salu_clr_size = 2'd0;
        tick();
        check("setwin_busy", 128'(busy_q), 128'(104'h30_0000));
        check("setwin_cnt", 128'(busy_cnt), 128'(2));

        // Flush beats same-cycle set
        drive_set(40, 3);
        flush = 1;
        tick();
        check("flushwin_busy", 128'(busy_q), 128'(0));
        check("flushwin_cnt", 128'(busy_cnt), 128'(0));

        // No forwarding: clear of reg 30 in the check cycle is not seen
        drive_set(30, 0);
        tick();
        drive_chk0(30, 0, 1'b0);
        salu_clr_valid = 1; salu_clr_addr = 7'd30; salu_clr_size = 2'd0;
        tick();
        check_result("nofwd");
        check("nofwd_busy", 128'(busy_q), 128'(0));

        // No operand enabled -> free
        chk_valid = 1;
        exp_q.push_back(1'b1);
        tick();
        check_result("noen");

        // Multi-operand, back-to-back checks against bits 50..57
        drive_set(50, 3);
        tick();
        check("set50_cnt", 128'(busy_cnt), 128'(8));
        drive_chk0(5, 0, 1'b1);
        chk_addr1 = 7'd57; chk_size1 = 2'd0; chk_en1 = 0;
        chk_addr2 = 7'd60; chk_size2 = 2'd3; chk_en2 = 1;
        @(posedge clk);
        #1;
        check_result("multi_free");
        drive_chk0(5, 0, 1'b0);
        chk_addr2 = 7'd57; chk_size2 = 2'd0; chk_en2 = 1;
        tick();
        check_result("multi_busy");

        // Flush in check cycle does not alter that check's result
        drive_chk0(54, 1, 1'b0);
        flush = 1;
        tick();
        check_result("flushchk");
        check("flushchk_busy", 128'(busy_q), 128'(0));

        // Reset between chk_valid and result discards the check
        drive_set(70, 0);
        tick();
        drive_chk0(70, 0, 1'b0);
        void'(exp_q.pop_back());
        #3;
        rst_n = 0;
        @(posedge clk);
        #1;
        idle_inputs();
        check("rstchk_done", 128'(chk_done), 128'(0));
        check("rstchk_busy", 128'(busy_q), 128'(0));
        check("rstchk_cnt", 128'(busy_cnt), 128'(0));
        rst_n = 1;
        tick();
        check("err_clean", 128'(err), 128'(0));

        // Double allocation of reg 5
        drive_set(5, 0);
        tick();
        drive_set(5, 0);
        tick();
        check("dbl_err", 128'(err), 128'(exp_err_dbl));
        salu_clr_valid = 1; salu_clr_addr = 7'd5; salu_clr_size = 2'd0;
        tick();
        check("dbl_err_sticky", 128'(err), 128'(exp_err_dbl));
        check("dbl_busy", 128'(busy_q), 128'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
